// File: rtl/game_pkg.sv
// Shared types and coordinate helpers for the defender-side board logic.
package game_pkg;

  localparam int unsigned ROW_MSB = 7;
  localparam int unsigned ROW_LSB = 4;
  localparam int unsigned COL_MSB = 3;
  localparam int unsigned COL_LSB = 0;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } resp_state_t;

  // True when both row and column of a packed coordinate fall inside the board.
  function automatic logic pos_in_range(input logic [7:0] pos, input int unsigned size);
    logic [4:0] lim;
    lim = 5'(size);
    return ({1'b0, pos[ROW_MSB:ROW_LSB]} < lim) && ({1'b0, pos[COL_MSB:COL_LSB]} < lim);
  endfunction

endpackage

// File: rtl/board_mem.sv
// Fleet map storage: BOARD_SIZE^2 two-bit cells with a shot lookup port,
// a display port, a single write port with combinational peek, and bulk clear.
module board_mem
  import game_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [7:0]  rd_pos,
  output cell_t       rd_cell,
  input  logic        wr_en,
  input  logic [7:0]  wr_pos,
  input  cell_t       wr_cell,
  output cell_t       cur_cell,
  input  logic [7:0]  disp_pos,
  output logic [1:0]  disp_cell
);

  localparam int unsigned NCELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int unsigned IDX_W  = $clog2(NCELLS);

  cell_t cells [NCELLS];

  function automatic logic [IDX_W-1:0] idx_of(input logic [7:0] pos);
    return IDX_W'(pos[ROW_MSB:ROW_LSB]) * IDX_W'(BOARD_SIZE) + IDX_W'(pos[COL_MSB:COL_LSB]);
  endfunction

  // Current content at the write address; out-of-range reads as empty.
  always_comb begin
    cur_cell = CELL_EMPTY;
    if (pos_in_range(wr_pos, BOARD_SIZE)) cur_cell = cells[idx_of(wr_pos)];
  end

  // Cell array: clear wipes everything, otherwise one cell written per cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < int'(NCELLS); i++) cells[i] <= CELL_EMPTY;
    end else if (wr_en) begin
      cells[idx_of(wr_pos)] <= wr_cell;
    end
  end

  // Registered lookup for the shot FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cell <= CELL_EMPTY;
    end else if (rd_en) begin
      rd_cell <= pos_in_range(rd_pos, BOARD_SIZE) ? cells[idx_of(rd_pos)] : CELL_EMPTY;
    end
  end

  // Registered display read; off-board queries read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cell <= 2'd0;
    end else begin
      disp_cell <= pos_in_range(disp_pos, BOARD_SIZE) ? cells[idx_of(disp_pos)] : CELL_EMPTY;
    end
  end

endmodule

// File: rtl/shot_responder.sv
// Defender-side shot resolver: holds the local fleet map, resolves incoming
// shots into hit/miss/repeat/invalid responses and tracks fleet destruction.
// Optional SHOT_RESPONDER_STATS_EN adds saturating shots_total/hits_total.
module shot_responder
  import game_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = 10,
  parameter int unsigned SHIP_CELLS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup_en,
  input  logic       clear_board,
  input  logic       place_valid,
  input  logic [7:0] place_pos,
  output logic       place_err,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic       shot_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_hit,
  output logic       resp_repeat,
  output logic       resp_invalid,
  output logic [4:0] cells_left,
  output logic       all_sunk,
  input  logic [7:0] disp_pos,
  output logic [1:0] disp_cell
`ifdef SHOT_RESPONDER_STATS_EN
  ,
  output logic [6:0] shots_total,
  output logic [4:0] hits_total
`endif
);

  localparam int unsigned CNT_W = 5;

  resp_state_t state;
  logic [7:0]  shot_q;
  logic        oor_q;
  logic        placed_any;

  cell_t       rd_cell;
  cell_t       cur_cell_c;
  logic        place_act_c;
  logic        place_ok_c;
  logic        upd_write_c;
  logic        wr_en_c;
  logic [7:0]  wr_pos_c;
  cell_t       wr_cell_c;

  assign shot_ready = (state == ST_IDLE) && !setup_en && !clear_board;

  // Shared write port: shot resolution in UPDATE, ship placement in IDLE.
  always_comb begin
    place_act_c = setup_en && place_valid && (state == ST_IDLE);
    place_ok_c  = pos_in_range(place_pos, BOARD_SIZE) && (cur_cell_c == CELL_EMPTY) &&
                  (cells_left < CNT_W'(SHIP_CELLS));
    upd_write_c = (state == ST_UPDATE) && !oor_q &&
                  ((rd_cell == CELL_SHIP) || (rd_cell == CELL_EMPTY));
    wr_en_c     = !clear_board && (upd_write_c || (place_act_c && place_ok_c));
    wr_pos_c    = (state == ST_UPDATE) ? shot_q : place_pos;
    wr_cell_c   = CELL_SHIP;
    if (state == ST_UPDATE) wr_cell_c = (rd_cell == CELL_SHIP) ? CELL_HIT : CELL_MISS;
  end

  board_mem #(
    .BOARD_SIZE(BOARD_SIZE)
  ) u_board (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_board),
    .rd_en    (state == ST_LOOKUP),
    .rd_pos   (shot_q),
    .rd_cell  (rd_cell),
    .wr_en    (wr_en_c),
    .wr_pos   (wr_pos_c),
    .wr_cell  (wr_cell_c),
    .cur_cell (cur_cell_c),
    .disp_pos (disp_pos),
    .disp_cell(disp_cell)
  );

  // Shot FSM, placement bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst || clear_board) begin
      state        <= ST_IDLE;
      shot_q       <= 8'd0;
      oor_q        <= 1'b0;
      placed_any   <= 1'b0;
      cells_left   <= '0;
      all_sunk     <= 1'b0;
      place_err    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_repeat  <= 1'b0;
      resp_invalid <= 1'b0;
`ifdef SHOT_RESPONDER_STATS_EN
      shots_total  <= '0;
      hits_total   <= '0;
`endif
    end else begin
      place_err <= 1'b0;
      all_sunk  <= placed_any && (cells_left == '0);
      case (state)
        ST_IDLE: begin
          if (shot_valid && shot_ready) begin
            shot_q <= shot_pos;
            state  <= ST_LOOKUP;
          end else if (place_act_c) begin
            if (place_ok_c) begin
              cells_left <= cells_left + CNT_W'(1);
              placed_any <= 1'b1;
            end else begin
              place_err <= 1'b1;
            end
          end
        end
        ST_LOOKUP: begin
          oor_q <= !pos_in_range(shot_q, BOARD_SIZE);
          state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          resp_valid   <= 1'b1;
          resp_hit     <= 1'b0;
          resp_repeat  <= 1'b0;
          resp_invalid <= 1'b0;
          state        <= ST_RESP;
          if (oor_q) begin
            resp_invalid <= 1'b1;
          end else begin
            case (rd_cell)
              CELL_SHIP: begin
                resp_hit   <= 1'b1;
                cells_left <= cells_left - CNT_W'(1);
              end
              CELL_HIT: begin
                resp_hit    <= 1'b1;
                resp_repeat <= 1'b1;
              end
              CELL_MISS: resp_repeat <= 1'b1;
              default:   resp_hit    <= 1'b0;
            endcase
`ifdef SHOT_RESPONDER_STATS_EN
            if ((rd_cell == CELL_SHIP) || (rd_cell == CELL_EMPTY)) begin
              if (shots_total != 7'h7F) shots_total <= shots_total + 7'd1;
              if ((rd_cell == CELL_SHIP) && (hits_total != 5'h1F)) hits_total <= hits_total + 5'd1;
            end
`endif
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_repeat  <= 1'b0;
            resp_invalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
